// File: rtl/ffram_arbiter.sv
// ffram_arbiter
//   Two-requester round-robin arbiter and init sequencer for a single-port
//   flip-flop RAM whose read data is combinational from the address.
//   After reset every RAM entry is written with INIT_VAL (one entry per
//   cycle). The arbiter then grants at most one requester per cycle to the
//   RAM port and returns registered read data to the requester that won.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   rX_req/wen/addr/din requester X access request (X = 0, 1)
//   rX_gnt              requester X granted this cycle (combinational)
//   rX_rvalid           one-cycle pulse, the cycle after a read is accepted
//   rX_rdata            registered read data, held until that port's next read
//   init_busy           high while the init sweep runs
//   mem_addr/din/wen    RAM port; mem_wen forced low while reset is asserted
//   mem_dout            RAM read data, combinational from mem_addr
//   dbg_state           current FSM state (0 = INIT, 1 = ARB)
//
// Handshake: a requester raises req with wen/addr/din and holds all of them
// stable until it sees gnt; the access is accepted in the cycle where
// req & gnt is high, and the requester may change or drop its inputs in the
// following cycle. An ungranted request has no side effects.
module ffram_arbiter #(
  parameter int                ADDR_W   = 1,
  parameter int                DATA_W   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_wen,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_din,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wen,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_din,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              init_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              dbg_state
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  // Last entry of the sweep (DEPTH-1 with DEPTH = 2**ADDR_W).
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              prio_q, prio_d;       // 0: requester 0 wins a tie
  logic              r0_rvalid_q, r0_rvalid_d;
  logic              r1_rvalid_q, r1_rvalid_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

  logic gnt0, gnt1;
  logic wen_raw;

  // Grant: only in ARB; a tie goes to the priority holder.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_ARB) begin
      if (r0_req && (!r1_req || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (r1_req) begin
        gnt1 = 1'b1;
      end
    end
  end

  // RAM port mux: init sweep, granted requester, or idle zeros.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    wen_raw  = 1'b0;
    if (state_q == ST_INIT) begin
      mem_addr = cnt_q;
      mem_din  = INIT_VAL;
      wen_raw  = 1'b1;
    end else if (gnt0) begin
      mem_addr = r0_addr;
      mem_din  = r0_din;
      wen_raw  = r0_wen;
    end else if (gnt1) begin
      mem_addr = r1_addr;
      mem_din  = r1_din;
      wen_raw  = r1_wen;
    end
  end

  // The state register is already in INIT during reset, which would leave
  // the write strobe high; gate it with reset so the RAM is never written
  // while reset is held.
  assign mem_wen = wen_raw & reset;

  // Next-state and registered read path.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    r0_rvalid_d = 1'b0;
    r1_rvalid_d = 1'b0;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
    case (state_q)
      ST_INIT: begin
        // Counter stops at the last entry rather than wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ARB: begin
        if (gnt0) begin
          prio_d = 1'b1;
          if (!r0_wen) begin
            r0_rvalid_d = 1'b1;
            r0_rdata_d  = mem_dout;
          end
        end else if (gnt1) begin
          prio_d = 1'b0;
          if (!r1_wen) begin
            r1_rvalid_d = 1'b1;
            r1_rdata_d  = mem_dout;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign init_busy = (state_q == ST_INIT);
  assign dbg_state = (state_q == ST_ARB);

endmodule

// File: tb/tb_ffram_arbiter.sv
// tb_ffram_arbiter
//   Bench for ffram_arbiter with DEPTH = 2, DATA_W = 1, INIT_VAL = 0.
//   A simple RAM sits on the mem_* port. A reference model holds the
//   expected memory contents, priority and read results as plain arrays and
//   flags; every cycle it predicts grants, the RAM port and the read
//   outputs, and each prediction is checked with an immediate assertion.
module tb_ffram_arbiter;
  localparam int                ADDR_W   = 1;
  localparam int                DATA_W   = 1;
  localparam logic [DATA_W-1:0] INIT_VAL = '0;
  localparam int                DEPTH    = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              r0_req, r0_wen, r1_req, r1_wen;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_din, r1_din;
  logic              r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              init_busy, mem_wen, dbg_state;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;

  ffram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_wen(r0_wen), .r0_addr(r0_addr), .r0_din(r0_din),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wen(r1_wen), .r1_addr(r1_addr), .r1_din(r1_din),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .init_busy(init_busy), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wen(mem_wen), .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  // Flip-flop RAM with combinational read.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) if (mem_wen) ram[mem_addr] <= mem_din;
  assign mem_dout = ram[mem_addr];

  // ---------------- reference model ----------------
  bit                m_init;
  int                m_cnt;
  int                m_prio;
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_rv0, m_rv1;
  logic [DATA_W-1:0] m_rd0, m_rd1;
  bit                last_acc0, last_acc1;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    m_cnt  = 0;
    m_prio = 0;
    m_rv0  = 1'b0;
    m_rv1  = 1'b0;
    m_rd0  = '0;
    m_rd1  = '0;
  endtask

  // One clock cycle: predict and check at the falling edge, advance the
  // model at the rising edge, return 1 time unit later for the driver.
  task automatic cycle();
    bit                g0, g1;
    logic              e_wen;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_init) begin
      if (r0_req && r1_req) begin
        if (m_prio == 0) g0 = 1'b1; else g1 = 1'b1;
      end else if (r0_req) begin
        g0 = 1'b1;
      end else if (r1_req) begin
        g1 = 1'b1;
      end
    end
    e_wen  = 1'b0;
    e_addr = '0;
    e_din  = '0;
    if (m_init) begin
      e_wen  = reset;
      e_addr = m_cnt[ADDR_W-1:0];
      e_din  = INIT_VAL;
    end else if (g0) begin
      e_wen = r0_wen; e_addr = r0_addr; e_din = r0_din;
    end else if (g1) begin
      e_wen = r1_wen; e_addr = r1_addr; e_din = r1_din;
    end
    chk("init_busy", init_busy, m_init);
    chk("dbg_state", dbg_state, !m_init);
    chk("r0_gnt",    r0_gnt,    g0);
    chk("r1_gnt",    r1_gnt,    g1);
    chk("mem_wen",   mem_wen,   e_wen);
    chk("mem_addr",  mem_addr,  e_addr);
    chk("mem_din",   mem_din,   e_din);
    chk("r0_rvalid", r0_rvalid, m_rv0);
    chk("r1_rvalid", r1_rvalid, m_rv1);
    chk("r0_rdata",  r0_rdata,  m_rd0);
    chk("r1_rdata",  r1_rdata,  m_rd1);
    last_acc0 = g0;
    last_acc1 = g1;
    @(posedge clk);
    if (reset) begin
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      if (m_init) begin
        m_mem[m_cnt] = INIT_VAL;
        if (m_cnt == DEPTH - 1) m_init = 1'b0;
        else m_cnt++;
      end else if (g0) begin
        if (r0_wen) m_mem[r0_addr] = r0_din;
        else begin m_rv0 = 1'b1; m_rd0 = m_mem[r0_addr]; end
        m_prio = 1;
      end else if (g1) begin
        if (r1_wen) m_mem[r1_addr] = r1_din;
        else begin m_rv1 = 1'b1; m_rd1 = m_mem[r1_addr]; end
        m_prio = 0;
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic req, input logic wen, input int addr, input int din);
    r0_req = req; r0_wen = wen; r0_addr = ADDR_W'(addr); r0_din = DATA_W'(din);
  endtask

  task automatic drive1(input logic req, input logic wen, input int addr, input int din);
    r1_req = req; r1_wen = wen; r1_addr = ADDR_W'(addr); r1_din = DATA_W'(din);
  endtask

  // A requester keeps a pending request until it is accepted.
  task automatic drive_random();
    if (!r0_req || last_acc0)
      drive0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, DEPTH - 1), int'($urandom));
    if (!r1_req || last_acc1)
      drive1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, DEPTH - 1), int'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_r0_gnt"},    r0_gnt,    1'b0);
    chk({tag, "_r1_gnt"},    r1_gnt,    1'b0);
    chk({tag, "_r0_rvalid"}, r0_rvalid, 1'b0);
    chk({tag, "_r1_rvalid"}, r1_rvalid, 1'b0);
    chk({tag, "_r0_rdata"},  r0_rdata,  '0);
    chk({tag, "_r1_rdata"},  r1_rdata,  '0);
    chk({tag, "_mem_wen"},   mem_wen,   1'b0);
    chk({tag, "_init_busy"}, init_busy, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    last_acc0 = 1'b0;
    last_acc1 = 1'b0;
    model_reset();
    #2 reset = 1'b0;
    #1 check_reset_outputs("por");
    cycle();
    cycle();
    check_reset_outputs("por_held");

    // Release with r1 already requesting a read of addr 0: it must wait out
    // both INIT cycles and win the first ARB cycle.
    drive1(1, 0, 0, 0);
    reset = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("first_arb_r1_gnt", last_acc1, 1'b1);
    drive1(0, 0, 0, 0);
    drive0(1, 0, 1, 0);   // read addr 1 after init
    cycle();
    drive0(0, 0, 0, 0);
    cycle();
    chk("init_rd0", r1_rdata, '0);
    chk("init_rd1", r0_rdata, '0);

    // r0 writes addr1 = 1 then reads it back.
    drive0(1, 1, 1, 1);
    cycle();
    drive0(1, 0, 1, 0);
    cycle();
    drive0(0, 0, 0, 0);
    cycle();
    chk("wr_rd_r0_rdata", r0_rdata, 1);
    chk("wr_rd_r1_rdata", r1_rdata, 0);

    // r1 access so r0 holds priority, then both contend for 6 cycles.
    drive1(1, 0, 1, 0);
    cycle();
    drive1(0, 0, 0, 0);
    cycle();
    drive0(1, 0, 0, 0);
    drive1(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_r0_turn", last_acc0, (i % 2 == 0));
    end
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    cycle();

    // r0 writes addr0 = 1, r1 reads addr0 in the next cycle.
    drive0(1, 1, 0, 1);
    cycle();
    drive0(0, 0, 0, 0);
    drive1(1, 0, 0, 0);
    cycle();
    drive1(0, 0, 0, 0);
    cycle();
    chk("fwd_r1_rdata", r1_rdata, 1);

    // Read addr0 (=1) so an rvalid is pending, then pulse reset mid-stream.
    drive0(1, 0, 0, 0);
    cycle();
    drive0(0, 0, 0, 0);
    reset = 1'b0;
    #1 check_reset_outputs("mid");
    model_reset();
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    drive0(1, 0, 0, 0);
    cycle();
    drive0(0, 0, 0, 0);
    cycle();
    chk("reinit_rd0", r0_rdata, '0);

    // Randomized traffic with the hold-until-accepted rule.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ffram_arbiter.md
Name: ffram_arbiter

Overview:
Two-requester round-robin arbiter and init sequencer for a single-port flip-flop RAM with combinational read data. After reset it clears every RAM entry. It then grants at most one requester per cycle to the shared RAM port and returns registered read data to the winning requester. It sits between two client blocks and one ffram-style storage instance.

Parameters:
ADDR_W, 1, RAM address width; DEPTH = 2**ADDR_W entries
DATA_W, 1, RAM data width
INIT_VAL, 0, value written to every entry during init (DATA_W bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
r0_req  input  1  requester 0 access request
r0_wen  input  1  requester 0: 1 = write, 0 = read
r0_addr  input  ADDR_W  requester 0 address
r0_din  input  DATA_W  requester 0 write data
r0_gnt  output  1  requester 0 granted this cycle (combinational)
r0_rvalid  output  1  requester 0 read data valid (one-cycle pulse)
r0_rdata  output  DATA_W  requester 0 read data (registered)
r1_req, r1_wen, r1_addr, r1_din, r1_gnt, r1_rvalid, r1_rdata: same as r0_*, for requester 1
init_busy  output  1  high while the init sweep is running
mem_addr  output  ADDR_W  RAM address
mem_din  output  DATA_W  RAM write data
mem_wen  output  1  RAM write enable
mem_dout  input  DATA_W  RAM read data, combinational from mem_addr

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = INIT, init counter = 0, round-robin priority = requester 0.
  - r*_gnt = 0, r*_rvalid = 0, r*_rdata = 0, init_busy = 1.
  - mem_wen is forced to 0 combinationally while reset = 0.
- State INIT:
  - mem_addr = counter, mem_din = INIT_VAL, mem_wen = 1, all gnt = 0.
  - The counter increments on each clock edge.
  - On the edge that writes DEPTH-1, move to ARB. INIT therefore lasts exactly DEPTH cycles after reset release.
  - init_busy = 1 only in INIT.
- State ARB, combinational grant:
  - Exactly one req high: grant that requester.
  - Both high: grant the priority holder.
  - Neither high: no grant; mem_wen = 0, mem_addr = 0, mem_din = 0.
  - At most one gnt is high in any cycle.
- Accept = req & gnt. mem_addr, mem_din and mem_wen are driven from the granted requester's inputs.
- Priority: after an accept by requester i, priority passes to requester 1-i on the next edge. With no accept, priority is unchanged.
- Requester rules:
  - A requester holds req, wen, addr and din stable until it sees gnt.
  - It may change or drop them in the cycle after an accept.
  - An ungranted request stays pending with no side effects.
- Read accepted at edge T:
  - rX_rdata <= mem_dout at T.
  - rX_rvalid = 1 for the single cycle after T.
  - rX_rdata holds its value until that port's next read.
- Write accepted: the RAM updates at that edge; no rvalid is produced.
- Write at T and read of the same address at T+1, from either port: the read returns the new data.
- Back-to-back accepts by the same requester are allowed only when the other requester is idle.
- Requests raised during INIT are not granted; they are first eligible in the cycle init_busy falls.
- Reset mid-operation: all outputs return to reset values immediately and any pending rvalid is dropped. The full INIT sweep re-runs after release.
- Two states (INIT, ARB); no other states. Counter width is ADDR_W; it does not wrap past DEPTH-1.

Test Plan:
- Release reset (DEPTH=2) -> init_busy = 1 for 2 cycles; mem_wen = 1 with mem_addr 0 then 1, mem_din = 0. Then reading addr 0 and addr 1 returns rdata = 0.
- r0 writes addr1 din1, then r0 reads addr1 -> r0_gnt in the same cycle as req; r0_rvalid one cycle after the read accept; r0_rdata = 1; r1 outputs unchanged.
- r0_req and r1_req both held high reading addr 0 for 6 cycles after init -> gnt sequence r0, r1, r0, r1, r0, r1. Each rvalid is a single cycle, one cycle after its grant.
- r1_req held high from reset release -> r1_gnt = 0 during both INIT cycles; r1_gnt = 1 in the first cycle init_busy = 0.
- Write 1 to addr0, then assert reset for 1 cycle mid-stream -> gnt and rvalid go to 0 immediately; INIT re-runs; a later read of addr0 returns 0.
- r0 writes addr0 = 1 at cycle T, r1 reads addr0 at T+1 -> r1_rvalid at T+2 with r1_rdata = 1.
